jtframe_cen_bank: RTL

Multi-channel fractional clock-enable generator: the programmable, single-clock successor to the fixed-ratio multi-output PLL wrappers. From one system clock it produces CH independent enable pairs (cen, cenb), each at a runtime-selectable ratio n/m, plus a `locked` indication. Game cores use it to derive CPU, video and sound enables without a dedicated PLL per frequency set, and retune them (e.g. for a different board revision) without re-synthesis.

---
 rtl/jtframe_cen_bank.sv | 116 +++++++++++
 1 files changed

// File: rtl/jtframe_cen_bank.sv
// Multi-channel fractional clock-enable generator: CH independent cen/cenb pairs at
// runtime-selectable n/m ratios, with a global lock indication.
module jtframe_cen_bank #(
  parameter int unsigned CH       = 6,
  parameter int unsigned W        = 10,
  parameter int unsigned LOCK_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [CH*W-1:0] n,
  input  logic [CH*W-1:0] m,
  output logic [CH-1:0]   cen,
  output logic [CH-1:0]   cenb,
  output logic [CH-1:0]   bad,
  output logic            locked
);

  localparam int unsigned CW = $clog2(LOCK_CYC + 1);
  localparam logic [CW-1:0] LockMax = CW'(LOCK_CYC);

  logic [CH-1:0] change;
  logic [CH-1:0] bad_d;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0]   n_in, m_in;
    logic [W-1:0]   sn_q, sm_q, sn_d, sm_d;
    logic [W:0]     acc_q, acc_d;
    logic [W+1:0]   sum;
    logic           ph_q, ph_d;
    logic           cen_q, cen_d, cenb_q, cenb_d, bad_q;
    logic           valid;

    assign n_in      = n[i*W +: W];
    assign m_in      = m[i*W +: W];
    assign change[i] = (n_in != sn_q) || (m_in != sm_q);
    assign sn_d      = change[i] ? n_in : sn_q;
    assign sm_d      = change[i] ? m_in : sm_q;
    // bad tracks the shadow as it will stand after this edge
    assign bad_d[i]  = !((sm_d != '0) && ({sn_d, 1'b0} <= {1'b0, sm_d}));
    assign valid     = (sm_q != '0) && ({sn_q, 1'b0} <= {1'b0, sm_q});
    assign sum       = {1'b0, acc_q} + {1'b0, sn_q, 1'b0};

    always_comb begin
      acc_d  = acc_q;
      ph_d   = ph_q;
      cen_d  = 1'b0;
      cenb_d = 1'b0;
      if (change[i] || !valid) begin
        acc_d = '0;
        ph_d  = 1'b0;
      end else if (enable) begin
        if (sum >= {2'b00, sm_q}) begin
          // sum < 2m here, so the difference fits in W+1 bits
          acc_d  = sum[W:0] - {1'b0, sm_q};
          ph_d   = ~ph_q;
          cen_d  = ~ph_q;
          cenb_d = ph_q;
        end else begin
          acc_d = sum[W:0];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sn_q   <= '0;
        sm_q   <= '0;
        acc_q  <= '0;
        ph_q   <= 1'b0;
        cen_q  <= 1'b0;
        cenb_q <= 1'b0;
        bad_q  <= 1'b0;
      end else begin
        sn_q   <= sn_d;
        sm_q   <= sm_d;
        acc_q  <= acc_d;
        ph_q   <= ph_d;
        cen_q  <= cen_d;
        cenb_q <= cenb_d;
        bad_q  <= bad_d[i];
      end
    end

    assign cen[i]  = cen_q;
    assign cenb[i] = cenb_q;
    assign bad[i]  = bad_q;
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          locked_q, locked_d;

  always_comb begin
    if (|change) begin
      cnt_d = '0;
    end else if (cnt_q == LockMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    locked_d = (cnt_d == LockMax) && !(|bad_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule
